// File: rtl/uart_rx_peripheral_pkg.sv
// Shared definitions for the UART receive peripheral: bus widths, register
// offsets within the 16-byte window, STATUS/CTRL bit positions and the
// receiver FSM encoding.
package uart_rx_peripheral_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // Byte offsets from the peripheral base address
    localparam logic [3:0] OFF_RXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_BAUD   = 4'hC;

    // STATUS bit positions
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    // CTRL bit positions
    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_INT_EN = 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_peripheral_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset (pointers and count only)
//   push_i   write wdata_i this cycle
//   pop_i    remove the head this cycle
//   wdata_i  data to push
//   head_o   oldest entry (undefined content when empty)
//   full_o   DEPTH entries held
//   empty_o  no entries held
//   count_o  number of entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    // On a full FIFO the write slot is the one being popped this cycle
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_peripheral.sv
// uart_rx_peripheral: memory-mapped 8N1 UART receiver with a receive FIFO
// and a level interrupt.
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   we, re        one-cycle bus write / read strobes (re on RXDATA pops)
//   addr, wdata   bus byte address and write data
//   rdata         read data, combinational from addr
//   uart_rxd      asynchronous serial input, idles high
//   rx_interrupt  registered level interrupt
// Registers: +0 RXDATA (RO), +4 STATUS (RO / W1C), +8 CTRL, +C BAUD.
module uart_rx_peripheral
    import uart_rx_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [BUS_AW-1:0] addr,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rdata,
    input  logic              uart_rxd,
    output logic              rx_interrupt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic [BUS_AW-1:0] off_full;
    logic [3:0]        off;
    logic              in_win;
    logic              wr_status, wr_ctrl, wr_baud, pop_req;

    // Registers
    logic              sync1_q, sync2_q;
    rx_state_e         state_q, state_d;
    logic [3:0]        samp_q, samp_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [15:0]       baud_q, baud_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;
    logic              int_q, int_d;

    logic              rxd_s, rx_en, tick;
    logic              push_req, ferr_set, ovr_set;
    logic [7:0]        fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     unused_fifo_count;
    logic              unused_wdata;

    // Window test works for any word-aligned base, not only 16-byte aligned
    assign off_full  = addr - BASE_ADDR;
    assign in_win    = (off_full[BUS_AW-1:4] == '0) && (off_full[1:0] == 2'b00);
    assign off       = off_full[3:0];
    assign wr_status = we & in_win & (off == OFF_STATUS);
    assign wr_ctrl   = we & in_win & (off == OFF_CTRL);
    assign wr_baud   = we & in_win & (off == OFF_BAUD);
    assign pop_req   = re & in_win & (off == OFF_RXDATA);

    assign rxd_s = sync2_q;
    assign rx_en = ctrl_q[CTRL_RX_EN];
    assign tick  = rx_en & (tick_cnt_q == baud_q);

    // A pop in the same cycle frees the slot, so only a lone push overruns
    assign ovr_set = push_req & fifo_full & ~pop_req;

    assign unused_wdata = ^wdata[BUS_DW-1:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .wdata_i (shift_q),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tick_cnt_d = tick_cnt_q;
        baud_d     = baud_q;
        push_req   = 1'b0;
        ferr_set   = 1'b0;

        if (rx_en) begin
            tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        end

        case (state_q)
            RX_IDLE: begin
                if (rx_en && !rxd_s) begin
                    tick_cnt_d = 16'd0;
                    samp_d     = 4'd0;
                    state_d    = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (samp_q == 4'd7) begin
                        // Line back high at mid start bit: treat as a glitch
                        if (!rxd_s) begin
                            samp_d  = 4'd0;
                            bit_d   = 3'd0;
                            state_d = RX_DATA;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (samp_q == 4'd15) begin
                        samp_d  = 4'd0;
                        shift_d = {rxd_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (samp_q == 4'd15) begin
                        push_req = rxd_s;
                        ferr_set = ~rxd_s;
                        state_d  = RX_IDLE;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (!rx_en) begin
            state_d = RX_IDLE;
        end
        // A new baud rate invalidates any frame in progress
        if (wr_baud) begin
            baud_d     = wdata[15:0];
            tick_cnt_d = 16'd0;
            state_d    = RX_IDLE;
        end
    end

    always_comb begin
        ctrl_d = wr_ctrl ? wdata[1:0] : ctrl_q;

        // Set after clear so a new error wins over a coincident W1C
        ovr_d = ovr_q;
        if (wr_status && wdata[ST_OVERRUN]) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end

        ferr_d = ferr_q;
        if (wr_status && wdata[ST_FRAME_ERR]) begin
            ferr_d = 1'b0;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end

        int_d = ctrl_q[CTRL_INT_EN] & (~fifo_empty | ovr_q | ferr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= RX_IDLE;
            samp_q     <= 4'd0;
            bit_q      <= 3'd0;
            tick_cnt_q <= 16'd0;
            baud_q     <= BAUD_RESET;
            ctrl_q     <= 2'b00;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            tick_cnt_q <= tick_cnt_d;
            baud_q     <= baud_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            int_q      <= int_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_interrupt = int_q;

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (off)
                OFF_RXDATA: rdata[7:0] = fifo_empty ? 8'h00 : fifo_head;
                OFF_STATUS: begin
                    rdata[ST_NOT_EMPTY] = ~fifo_empty;
                    rdata[ST_FULL]      = fifo_full;
                    rdata[ST_OVERRUN]   = ovr_q;
                    rdata[ST_FRAME_ERR] = ferr_q;
                end
                OFF_CTRL:   rdata[1:0]  = ctrl_q;
                OFF_BAUD:   rdata[15:0] = baud_q;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_peripheral.sv
module tb_uart_rx_peripheral;

    localparam logic [31:0] BASE = 32'h4000_0020;
    localparam logic [31:0] A_RX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_BD = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_rxd = 1'b1;
    logic        rx_interrupt;

    int total = 0;
    int bad = 0;

    // Scoreboard: bytes the receiver should hold, plus modelled flags
    logic [7:0] sb[$];
    bit m_ovr = 1'b0;
    bit m_ferr = 1'b0;

    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[6];

    uart_rx_peripheral #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .BAUD_RESET (16'd26)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .re           (re),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .uart_rxd     (uart_rxd),
        .rx_interrupt (rx_interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        re = 1'b0;
        #1 d = rdata;
    endtask

    task automatic peek_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        peek(a, d);
        check(name, d, exp);
    endtask

    task automatic expect_read(input string name);
        logic [31:0] d;
        logic [31:0] exp;
        @(negedge clk);
        addr = A_RX;
        re = 1'b1;
        #1 d = rdata;
        exp = (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'h0;
        check(name, d, exp);
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic check_int(input string name, input bit exp);
        check(name, {31'b0, rx_interrupt}, {31'b0, exp});
    endtask

    function automatic void sb_push(input logic [7:0] d);
        if (sb.size() < 4) sb.push_back(d);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_status();
        return {28'b0, m_ferr, m_ovr, sb.size() == 4, sb.size() != 0};
    endfunction

    // 32 clocks per bit (BAUD=1), LSB first, starting at the next negedge
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, d, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (32) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;

        vecs[0] = '{8'h3C, 1'b0, 32'h8};
        vecs[1] = '{8'h00, 1'b1, 32'h1};
        vecs[2] = '{8'hFF, 1'b1, 32'h1};
        vecs[3] = '{8'h96, 1'b1, 32'h1};
        vecs[4] = '{8'h81, 1'b0, 32'h8};
        vecs[5] = '{8'h01, 1'b1, 32'h1};

        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset values and decode boundaries
        peek_check("reset_rxdata", A_RX, 32'h0);
        peek_check("reset_status", A_ST, 32'h0);
        peek_check("reset_ctrl", A_CT, 32'h0);
        peek_check("reset_baud", A_BD, 32'd26);
        check_int("reset_int", 1'b0);
        bus_write(BASE + 32'h1C, 32'hFFFF);
        peek_check("outside_read", BASE + 32'h10, 32'h0);
        peek_check("outside_write_ignored", A_BD, 32'd26);

        bus_write(A_BD, 32'h1);
        bus_write(A_CT, 32'hFFFF_FFFF);
        peek_check("ctrl_rw", A_CT, 32'h3);
        peek_check("baud_rw", A_BD, 32'h1);

        // Basic frame: push lands on the stop-bit sample, interrupt one clock later
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                repeat (307) @(negedge clk);
                addr = A_ST;
                #1 check("basic_status_at_push", rdata, 32'h1);
                check_int("basic_int_not_yet", 1'b0);
                @(negedge clk);
                check_int("basic_int_next_cycle", 1'b1);
            end
        join
        sb_push(8'hA5);
        idle(5);
        expect_read("basic_rxdata");
        check_int("basic_int_still_high", 1'b1);
        @(negedge clk);
        check_int("basic_int_drop", 1'b0);
        peek_check("basic_status_after_pop", A_ST, 32'h0);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok);
            if (vecs[i].stop_ok) sb_push(vecs[i].data);
            else m_ferr = 1'b1;
            idle(40);
            peek_check($sformatf("vec%0d_status", i), A_ST, vecs[i].exp_status);
            check_int($sformatf("vec%0d_int", i), vecs[i].exp_status != 0);
            if (vecs[i].exp_status[0]) expect_read($sformatf("vec%0d_rxdata", i));
            bus_write(A_ST, 32'hC);
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            idle(2);
            peek_check($sformatf("vec%0d_status_clr", i), A_ST, model_status());
            check_int($sformatf("vec%0d_int_clr", i), 1'b0);
        end

        // Short low glitch: start-bit check rejects it
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (8) @(negedge clk);
        uart_rxd = 1'b1;
        idle(60);
        peek_check("glitch_status", A_ST, 32'h0);
        peek_check("glitch_rxdata", A_RX, 32'h0);

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            sb_push(8'(i));
        end
        idle(40);
        peek_check("ovf_status", A_ST, model_status());
        check("ovf_model_sanity", model_status(), 32'h7);
        for (int i = 0; i < 4; i++) expect_read($sformatf("ovf_read%0d", i));
        peek_check("ovf_status_drained", A_ST, 32'h4);
        bus_write(A_ST, 32'h4);
        m_ovr = 1'b0;
        peek_check("ovf_cleared", A_ST, 32'h0);

        // Full FIFO: pop in the exact cycle the fifth stop bit is accepted
        foreach (vecs[i]) if (i < 4) begin
            send_frame(8'h10 * 8'(i + 1), 1'b1);
            sb_push(8'h10 * 8'(i + 1));
        end
        fork
            send_frame(8'h50, 1'b1);
            begin
                logic [7:0] e;
                @(negedge clk);
                repeat (306) @(negedge clk);
                addr = A_RX;
                re = 1'b1;
                #1 e = sb.pop_front();
                check("simul_pop_value", rdata, {24'b0, e});
                @(negedge clk);
                re = 1'b0;
            end
        join
        sb_push(8'h50);
        idle(40);
        peek_check("simul_status", A_ST, model_status());
        for (int i = 0; i < 4; i++) expect_read($sformatf("simul_read%0d", i));
        peek_check("simul_empty", A_ST, 32'h0);

        // Reset asserted during DATA
        send_frame(8'hC3, 1'b1);
        sb_push(8'hC3);
        fork
            send_frame(8'h99, 1'b1);
            begin
                @(negedge clk);
                repeat (100) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        join
        sb.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        idle(40);
        peek_check("rst_status", A_ST, 32'h0);
        peek_check("rst_rxdata", A_RX, 32'h0);
        peek_check("rst_ctrl", A_CT, 32'h0);
        peek_check("rst_baud", A_BD, 32'd26);
        check_int("rst_int", 1'b0);

        // rx_en cleared mid-frame: partial byte lost, next frame received
        bus_write(A_BD, 32'h1);
        bus_write(A_CT, 32'h3);
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(negedge clk);
                repeat (100) @(negedge clk);
                bus_write(A_CT, 32'h2);
            end
        join
        idle(40);
        peek_check("dis_status", A_ST, 32'h0);
        bus_write(A_CT, 32'h3);
        idle(5);
        send_frame(8'h5A, 1'b1);
        sb_push(8'h5A);
        idle(40);
        peek_check("dis_status_after", A_ST, model_status());
        expect_read("dis_rxdata");
        peek_check("dis_status_final", A_ST, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
